mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the RV32I-subset core: lw, sw, R-type, I-type ALU, beq, jal.
- Replaces single-cycle control decoding with a Moore FSM. It sequences one shared instruction/data memory, the ALU, the register file and the PC/IR enables across several cycles per instruction.
- Sits between the instruction register fields (op/funct3/funct7b5), the ALU zero flag and memory ready, and the datapath mux selects/write enables.

Parameters:
- MEM_HANDSHAKE, 1, 1 = wait states honour mem_ready; 0 = mem_ready ignored, every memory state lasts exactly 1 cycle.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store enable, valid with mem_req
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC
- reg_write  out  1  register file write
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  000 add, 001 sub, 010 and, 110 or, 101 slt
- state_o  out  4  current state, debug only
- illegal_instr  out  1  see Optional Feature

Behaviour:
- Only sequential element: 4-bit state register, async-cleared to FETCH. All outputs are combinational from state/op/funct/zero/mem_ready.
- While rst_n = 0: mem_req, mem_write, ir_write, pc_write, reg_write and illegal_instr are forced 0; all selects are 0.
- Reset asserted mid-instruction aborts it. There is no partial write after release; execution restarts at FETCH.
- "rdy" = mem_ready (or 1 when MEM_HANDSHAKE = 0).
- FETCH:
  - mem_req = 1, adr_src = 0, a = 00, b = 10, alu_op = add, result_src = 10.
  - On rdy: ir_write = 1 and pc_write = 1 in the same cycle, next state DECODE. Otherwise hold in FETCH.
- DECODE: a = 01, b = 01, add (branch target into ALUOut). Next state by op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> FETCH (NOP)
- MEMADR: a = 10, b = 01, add. Next MEMREAD if op = lw, else MEMWRITE.
- MEMREAD: mem_req = 1, adr_src = 1, result_src = 00. On rdy -> MEMWB.
- MEMWB: result_src = 01, reg_write = 1 -> FETCH.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1, result_src = 00. Both held until rdy; on rdy -> FETCH.
- EXECR: a = 10, b = 00, alu_op = funct -> ALUWB.
- EXECI: a = 10, b = 01, alu_op = funct -> ALUWB.
- ALUWB: result_src = 00, reg_write = 1 -> FETCH.
- BEQ: a = 10, b = 00, sub, result_src = 00, pc_write = zero -> FETCH.
- JAL: a = 01, b = 10, add, result_src = 00, pc_write = 1 -> ALUWB (writes PC+4 to rd).
- Any unused state encoding -> FETCH next cycle, with all enables 0.
- imm_src decoded from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- alu_control decode:
  - alu_op add -> 000; sub -> 001.
  - alu_op funct, by funct3:
    - 000 -> 001 if op[5] & funct7b5, else 000
    - 010 -> 101
    - 110 -> 110
    - 111 -> 010
    - any other funct3 -> 000
- Cycle counts with zero-wait memory:
  - lw 5, sw 4, R/I 4, beq 3, jal 4, unknown op 2.
  - Each wait cycle adds 1 in FETCH/MEMREAD/MEMWRITE.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown op in DECODE -> TRAP state.
  - TRAP asserts illegal_instr = 1 with all enables 0, and holds until reset.
  - Unsupported funct3 in EXECR/EXECI also -> TRAP, from DECODE.
- Undefined:
  - No TRAP state; illegal_instr tied 0.
  - Unknown op is a NOP; unsupported funct3 executes as add.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants
  - alu_op enum (add/sub/funct)
  - alu_control codes
  - alu_src_a/alu_src_b/result_src/imm_src encodings
- One combinational sub-module, alu_dec: inputs alu_op, funct3, op[5], funct7b5; output alu_control.
- Main FSM and output decode stay in mc_ctrl.

Test Plan:
- Reset, then release with mem_ready = 1 -> state_o = FETCH, mem_req = 1, ir_write = 1, pc_write = 1 on the first cycle; no writes during reset.
- lw (op 0000011), mem_ready low 2 cycles in MEMREAD -> 7 cycles total, reg_write = 1 only in MEMWB with result_src = 01.
- sw, mem_ready = 1 -> mem_write = 1 exactly 1 cycle with adr_src = 1; reg_write never asserted; 4 cycles total.
- R-type funct3 000, funct7b5 1 -> alu_control 001 in EXECR; I-type funct3 000, funct7b5 1 -> 000 (op[5] = 0).
- beq with zero = 1 -> pc_write = 1 in BEQ; zero = 0 -> pc_write = 0; 3 cycles either way.
- op 1111111 -> NOP back to FETCH after 2 cycles; with MC_CTRL_ILLEGAL_TRAP_EN, illegal_instr = 1 held until rst_n = 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared types and encodings for the multi-cycle main
//               controller: FSM state enum, RV32I opcodes, ALU operation
//               classes, ALU control codes and datapath select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    // Controller states. ST_TRAP is only reachable when the illegal
    // instruction trap is built in; otherwise it behaves as an unused code.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_JAL      = 4'd10,
        ST_TRAP     = 4'd11
    } state_e;

    // Supported opcodes (IR[6:0])
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // ALU operation class requested by the FSM
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // ALU control codes
    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Immediate format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format implied by the opcode; unknown opcodes fall to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op_i);
        logic [1:0] r;
        case (op_i)
            OP_SW:   r = IMM_S;
            OP_BEQ:  r = IMM_B;
            OP_JAL:  r = IMM_J;
            default: r = IMM_I;
        endcase
        return r;
    endfunction

    // funct3 values the ALU decoder actually implements
    function automatic logic funct3_supported(input logic [2:0] f3_i);
        return (f3_i == 3'b000) || (f3_i == 3'b010) ||
               (f3_i == 3'b110) || (f3_i == 3'b111);
    endfunction

endpackage : mc_ctrl_pkg

`default_nettype wire

// File: rtl/mc_ctrl_alu_dec.sv
// ============================================================================
// Module      : alu_dec
// Description : Combinational ALU decoder. Turns the FSM's ALU operation
//               class plus funct3/op[5]/funct7b5 into the ALU control code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    // Map the operation class to a control code; funct decoding only
    // distinguishes sub from add for R-type (op[5] = 1) instructions.
    always_comb begin
        alu_control_o = ALUC_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALUC_ADD;
            ALUOP_SUB: alu_control_o = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_control_o = ALUC_SLT;
                    3'b110:  alu_control_o = ALUC_OR;
                    3'b111:  alu_control_o = ALUC_AND;
                    default: alu_control_o = ALUC_ADD;
                endcase
            end
            default: alu_control_o = ALUC_ADD;
        endcase
    end

endmodule : alu_dec

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// Module      : mc_ctrl
// Description : Moore-style multi-cycle main controller for the RV32I subset
//               (lw, sw, R-type, I-type ALU, beq, jal). Sequences the shared
//               memory, ALU, register file and PC/IR enables.
//               Optional build macro MC_CTRL_ILLEGAL_TRAP_EN adds a sticky
//               TRAP state for unknown opcodes / unsupported funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic [3:0] state_o,
    output logic       illegal_instr
);

    state_e     state_q;
    state_e     state_d;
    logic       w_rdy;

    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_result_src;
    alu_op_e    w_alu_op;
    logic [2:0] w_alu_control;

    // Memory completion: either the real handshake or a fixed single cycle
    generate
        if (MEM_HANDSHAKE) begin : g_mem_hs
            assign w_rdy = mem_ready;
        end else begin : g_mem_fixed
            logic w_unused_mem_ready;
            assign w_unused_mem_ready = mem_ready;
            assign w_rdy = 1'b1;
        end
    endgenerate

    // State register, asynchronously cleared to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (w_rdy) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    OP_R:         state_d = funct3_supported(funct3) ? ST_EXECR : ST_TRAP;
                    OP_I:         state_d = funct3_supported(funct3) ? ST_EXECI : ST_TRAP;
`else
                    OP_R:         state_d = ST_EXECR;
                    OP_I:         state_d = ST_EXECI;
`endif
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_JAL:       state_d = ST_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = ST_TRAP;
`else
                    default:      state_d = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR:   state_d = (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
            ST_MEMREAD:  state_d = w_rdy ? ST_MEMWB : ST_MEMREAD;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWRITE: state_d = w_rdy ? ST_FETCH : ST_MEMWRITE;
            ST_EXECR:    state_d = ST_ALUWB;
            ST_EXECI:    state_d = ST_ALUWB;
            ST_ALUWB:    state_d = ST_FETCH;
            ST_BEQ:      state_d = ST_FETCH;
            ST_JAL:      state_d = ST_ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP:     state_d = ST_TRAP;
`endif
            default:     state_d = ST_FETCH;
        endcase
    end

    // Per-state datapath controls (before reset gating)
    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RS2;
        w_result_src = RES_ALUOUT;
        w_alu_op     = ALUOP_ADD;
        case (state_q)
            ST_FETCH: begin
                // PC+4 goes straight from the ALU into the PC
                w_mem_req    = 1'b1;
                w_src_a      = SRCA_PC;
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURES;
                w_ir_write   = w_rdy;
                w_pc_write   = w_rdy;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
            end
            ST_MEMADR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
            end
            ST_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            ST_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
            end
            ST_EXECR: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_RS2;
                w_alu_op = ALUOP_FUNCT;
            end
            ST_EXECI: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                w_reg_write = 1'b1;
            end
            ST_BEQ: begin
                // Target already sits in ALUOut from DECODE
                w_src_a    = SRCA_RS1;
                w_src_b    = SRCB_RS2;
                w_alu_op   = ALUOP_SUB;
                w_pc_write = zero;
            end
            ST_JAL: begin
                // Jump target from ALUOut, ALU computes OldPC+4 for rd
                w_src_a    = SRCA_OLDPC;
                w_src_b    = SRCB_FOUR;
                w_pc_write = 1'b1;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: begin
                w_illegal = 1'b1;
            end
`endif
            default: begin
                w_illegal = 1'b0;
            end
        endcase
    end

    alu_dec u_alu_dec (
        .alu_op_i      (w_alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (w_alu_control)
    );

    // Reset gating: no enable or select may leak out while rst_n is low
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        imm_src       = 2'b00;
        alu_control   = 3'b000;
        if (rst_n) begin
            mem_req       = w_mem_req;
            mem_write     = w_mem_write;
            adr_src       = w_adr_src;
            ir_write      = w_ir_write;
            pc_write      = w_pc_write;
            reg_write     = w_reg_write;
            illegal_instr = w_illegal;
            alu_src_a     = w_src_a;
            alu_src_b     = w_src_b;
            result_src    = w_result_src;
            imm_src       = imm_src_of(op);
            alu_control   = w_alu_control;
        end
    end

    assign state_o = state_q;

endmodule : mc_ctrl

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Self-checking bench for mc_ctrl. Each instruction is expanded
//               into the list of per-cycle control words the instruction
//               must produce, then the DUT outputs are compared cycle by
//               cycle. Directed cases first, then random instructions with
//               random wait states and occasional mid-instruction resets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic [3:0] state_o;
    logic       illegal_instr;

    logic [17:0] obs;
    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  illegal_instr, alu_src_a, alu_src_b, result_src, imm_src, alu_control};

    int n_checks = 0;
    int n_pass   = 0;

    logic [17:0] exp_q[$];
    logic        rdy_q[$];

    mc_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .alu_control(alu_control), .state_o(state_o),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b110;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [17:0] mk(input logic mreq, input logic mw, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic ill, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [1:0] imm,
                                       input logic [2:0] alu);
        return {mreq, mw, adr, irw, pcw, rw, ill, a, b, rs, imm, alu};
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic push(input logic [17:0] e, input logic r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    // Assert reset at a falling edge, check the gated outputs, release
    // just after a rising edge so the next cycle starts cleanly in FETCH.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'($urandom);
        #1;
        chk({tag, " outputs_in_reset"}, 32'(obs), 32'd0);
        chk({tag, " state_in_reset"}, 32'(state_o), 32'(ST_FETCH));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 unknown
    task automatic run_instr(input int kind, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int wf, input int wm,
                             input int abort_at, input string nm);
        logic [1:0] im;
        bit         trap;
        bit         aborted;
        bit         bad_f3;
        im      = imm_of(o);
        trap    = 1'b0;
        aborted = 1'b0;
        bad_f3  = !(f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111);
        exp_q.delete();
        rdy_q.delete();
        // fetch with wait states, then decode
        for (int k = 0; k < wf; k++) push(mk(1,0,0,0,0,0,0, 2'b00,2'b10,2'b10, im, 3'b000), 1'b0);
        push(mk(1,0,0,1,1,0,0, 2'b00,2'b10,2'b10, im, 3'b000), 1'b1);
        push(mk(0,0,0,0,0,0,0, 2'b01,2'b01,2'b00, im, 3'b000), 1'($urandom));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        if (kind == 6 || ((kind == 2 || kind == 3) && bad_f3)) trap = 1'b1;
`endif
        if (trap) begin
            for (int k = 0; k < 3; k++) push(mk(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00, im, 3'b000), 1'($urandom));
        end else begin
            case (kind)
                0: begin
                    push(mk(0,0,0,0,0,0,0, 2'b10,2'b01,2'b00, im, 3'b000), 1'($urandom));
                    for (int k = 0; k < wm; k++) push(mk(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00, im, 3'b000), 1'b0);
                    push(mk(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00, im, 3'b000), 1'b1);
                    push(mk(0,0,0,0,0,1,0, 2'b00,2'b00,2'b01, im, 3'b000), 1'($urandom));
                end
                1: begin
                    push(mk(0,0,0,0,0,0,0, 2'b10,2'b01,2'b00, im, 3'b000), 1'($urandom));
                    for (int k = 0; k < wm; k++) push(mk(1,1,1,0,0,0,0, 2'b00,2'b00,2'b00, im, 3'b000), 1'b0);
                    push(mk(1,1,1,0,0,0,0, 2'b00,2'b00,2'b00, im, 3'b000), 1'b1);
                end
                2, 3: begin
                    push(mk(0,0,0,0,0,0,0, 2'b10, (kind == 2) ? 2'b00 : 2'b01, 2'b00, im,
                            funct_alu(o, f3, f7)), 1'($urandom));
                    push(mk(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, im, 3'b000), 1'($urandom));
                end
                4: push(mk(0,0,0,0,z,0,0, 2'b10,2'b00,2'b00, im, 3'b001), 1'($urandom));
                5: begin
                    push(mk(0,0,0,0,1,0,0, 2'b01,2'b10,2'b00, im, 3'b000), 1'($urandom));
                    push(mk(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, im, 3'b000), 1'($urandom));
                end
                default: ;
            endcase
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            op        = o;
            funct3    = f3;
            funct7b5  = f7;
            zero      = z;
            mem_ready = rdy_q[i];
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk($sformatf("%s abort_step%0d outputs", nm, i), 32'(obs), 32'd0);
                @(posedge clk);
                #1;
                rst_n   = 1'b1;
                aborted = 1'b1;
                break;
            end
            #1;
            if (i == 0) chk($sformatf("%s start_state", nm), 32'(state_o), 32'(ST_FETCH));
            chk($sformatf("%s step%0d ctl", nm, i), 32'(obs), 32'(exp_q[i]));
        end
        if (trap && !aborted) do_reset({nm, " trap_exit"});
    endtask

    initial begin
        int         kind;
        logic [6:0] o;
        int         ab;
        rst_n     = 1'b0;
        op        = 7'd0;
        funct3    = 3'd0;
        funct7b5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Held in reset with memory ready: nothing may be enabled
        @(negedge clk);
        #1;
        chk("reset outputs", 32'(obs), 32'd0);
        chk("reset state", 32'(state_o), 32'(ST_FETCH));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases
        run_instr(0, 7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2, -1, "lw_wait2");
        run_instr(1, 7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, -1, "sw");
        run_instr(2, 7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, -1, "r_sub");
        run_instr(3, 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, -1, "i_add");
        run_instr(2, 7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, -1, "r_and");
        run_instr(4, 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, -1, "beq_taken");
        run_instr(4, 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, -1, "beq_not");
        run_instr(5, 7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, -1, "jal");
        run_instr(6, 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1, "unknown");
        run_instr(0, 7'b0000011, 3'b010, 1'b0, 1'b0, 2, 1, -1, "lw_fetchwait");
        run_instr(0, 7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 4, "lw_abort_wb");
        run_instr(2, 7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0, -1, "r_badf3");

        // Random instructions
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1100011;
                5: o = 7'b1101111;
                default: begin
                    o = 7'($urandom);
                    while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111)
                        o = 7'($urandom);
                end
            endcase
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(kind, o, 3'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), ab,
                      $sformatf("rnd%0d_k%0d", n, kind));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mc_ctrl

`default_nettype wire
